// File: rtl/md_unit_if.sv
// Handshake/result bundle between the EX-stage issue logic and the multiply/divide unit.
// The issuing side drives start/MDctr/A/B; the unit returns busy and the HI/LO registers.
interface md_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [3:0]       MDctr;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, MDctr, A, B,
        input  busy, HI, LO
    );

    modport slave (
        input  start, MDctr, A, B,
        output busy, HI, LO
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is computed combinationally
// from latched operands; a down-counter holds busy for the configured number of cycles.
module md_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic    clk,
    input logic    reset,
    md_unit_if.slave md
);

    localparam int unsigned MaxCyc = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);
    localparam int unsigned ProdW  = 2 * WIDTH;

    typedef enum logic [3:0] {
        OpNone  = 4'd0,
        OpMult  = 4'd1,
        OpMultu = 4'd2,
        OpDiv   = 4'd3,
        OpDivu  = 4'd4,
        OpMthi  = 4'd5,
        OpMtlo  = 4'd6,
        OpMadd  = 4'd7,
        OpMaddu = 4'd8,
        OpMsub  = 4'd9,
        OpMsubu = 4'd10
    } md_op_e;

    typedef enum logic {StIdle, StBusy} state_e;

    state_e           state_q;
    md_op_e           op_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;

    logic [ProdW-1:0] prod_s, prod_u, acc;
    logic [WIDTH-1:0] a_mag, b_mag, b_mag_safe, b_safe;
    logic [WIDTH-1:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
    logic             b_nz;
    logic             res_wr;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign md.busy = (state_q == StBusy);
    assign md.HI   = hi_q;
    assign md.LO   = lo_q;

    always_comb begin
        prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
        prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        acc    = {hi_q, lo_q};

        // Signed divide via magnitudes; most-negative / -1 falls out as LO = A, HI = 0.
        b_nz       = (b_q != '0);
        a_mag      = a_q[WIDTH-1] ? ({WIDTH{1'b0}} - a_q) : a_q;
        b_mag      = b_q[WIDTH-1] ? ({WIDTH{1'b0}} - b_q) : b_q;
        b_mag_safe = b_nz ? b_mag : {{(WIDTH-1){1'b0}}, 1'b1};
        b_safe     = b_nz ? b_q : {{(WIDTH-1){1'b0}}, 1'b1};
        q_mag      = a_mag / b_mag_safe;
        r_mag      = a_mag % b_mag_safe;
        q_s        = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? ({WIDTH{1'b0}} - q_mag) : q_mag;
        r_s        = a_q[WIDTH-1] ? ({WIDTH{1'b0}} - r_mag) : r_mag;
        q_u        = a_q / b_safe;
        r_u        = a_q % b_safe;

        res_wr = 1'b0;
        res_hi = hi_q;
        res_lo = lo_q;
        case (op_q)
            OpMult:  begin res_wr = 1'b1; {res_hi, res_lo} = prod_s;       end
            OpMultu: begin res_wr = 1'b1; {res_hi, res_lo} = prod_u;       end
            OpMadd:  begin res_wr = 1'b1; {res_hi, res_lo} = acc + prod_s; end
            OpMaddu: begin res_wr = 1'b1; {res_hi, res_lo} = acc + prod_u; end
            OpMsub:  begin res_wr = 1'b1; {res_hi, res_lo} = acc - prod_s; end
            OpMsubu: begin res_wr = 1'b1; {res_hi, res_lo} = acc - prod_u; end
            OpDiv:   begin res_wr = b_nz; res_hi = r_s; res_lo = q_s;      end
            OpDivu:  begin res_wr = b_nz; res_hi = r_u; res_lo = q_u;      end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            op_q    <= OpNone;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (md.start) begin
                        case (md.MDctr)
                            OpMthi: hi_q <= md.A;
                            OpMtlo: lo_q <= md.A;
                            OpMult, OpMultu, OpMadd, OpMaddu, OpMsub, OpMsubu: begin
                                op_q    <= md_op_e'(md.MDctr);
                                a_q     <= md.A;
                                b_q     <= md.B;
                                cnt_q   <= CntW'(MULT_CYCLES);
                                state_q <= StBusy;
                            end
                            OpDiv, OpDivu: begin
                                op_q    <= md_op_e'(md.MDctr);
                                a_q     <= md.A;
                                b_q     <= md.B;
                                cnt_q   <= CntW'(DIV_CYCLES);
                                state_q <= StBusy;
                            end
                            default: ;
                        endcase
                    end
                end
                StBusy: begin
                    if (cnt_q == CntW'(1)) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        if (res_wr) begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: expected HI/LO come from an independent model and are queued at
// launch, then popped and compared when busy drops.
module tb_md_unit;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    logic clk;
    logic reset;
    md_unit_if #(.WIDTH(W)) bus ();

    md_unit #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] hi, input logic [W-1:0] lo,
                                  output logic [W-1:0] eh, output logic [W-1:0] el,
                                  output int n);
        longint     sa = $signed(a);
        longint     sbv = $signed(b);
        logic [63:0] ps = sa * sbv;
        logic [63:0] pu = {32'b0, a} * {32'b0, b};
        logic [63:0] acc = {hi, lo};
        eh = hi;
        el = lo;
        n  = 0;
        case (op)
            4'd1:  begin {eh, el} = ps;       n = 5; end
            4'd2:  begin {eh, el} = pu;       n = 5; end
            4'd3:  begin
                n = 10;
                if (b != 0) begin el = 32'(sa / sbv); eh = 32'(sa % sbv); end
            end
            4'd4:  begin
                n = 10;
                if (b != 0) begin el = a / b; eh = a % b; end
            end
            4'd5:  eh = a;
            4'd6:  el = a;
            4'd7:  begin {eh, el} = acc + ps; n = 5; end
            4'd8:  begin {eh, el} = acc + pu; n = 5; end
            4'd9:  begin {eh, el} = acc - ps; n = 5; end
            4'd10: begin {eh, el} = acc - pu; n = 5; end
            default: ;
        endcase
    endfunction

    // Called at a negedge; returns at the next negedge with start released.
    task automatic launch(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int n);
        exp_t e;
        model(op, a, b, m_hi, m_lo, e.hi, e.lo, n);
        sb.push_back(e);
        bus.start = 1'b1;
        bus.MDctr = op;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
    endtask

    task automatic finish(input string tag, input int n, input int cyc0);
        int   cyc = cyc0;
        exp_t e;
        while (bus.busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check({tag, "_cycles"}, 64'(cyc), 64'(n));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(0), 64'(1));
        end else begin
            e = sb.pop_front();
            check({tag, "_hi"}, 64'(bus.HI), 64'(e.hi));
            check({tag, "_lo"}, 64'(bus.LO), 64'(e.lo));
            m_hi = e.hi;
            m_lo = e.lo;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        int n;
        launch(op, a, b, n);
        finish(tag, n, 0);
    endtask

    initial begin
        int n;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.MDctr = '0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_hi", 64'(bus.HI), 64'(0));
        check("rst_lo", 64'(bus.LO), 64'(0));
        reset = 1'b1;

        run_op("mthi", 4'd5, 32'h1234, 32'h0);
        check("mthi_const", 64'(bus.HI), 64'h1234);

        run_op("mult", 4'd1, 32'hFFFF_FFFD, 32'd7);
        check("mult_const", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("multu", 4'd2, 32'hFFFF_FFFD, 32'd7);
        check("multu_const", {bus.HI, bus.LO}, 64'h0000_0006_FFFF_FFEB);

        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2);
        check("div_const", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_const", {bus.HI, bus.LO}, 64'h0000_0000_8000_0000);
        run_op("divu_z", 4'd4, 32'd7, 32'd0);
        check("divu_z_const", {bus.HI, bus.LO}, 64'h0000_0000_8000_0000);

        run_op("mtlo", 4'd6, 32'hFFFF_FFFF, 32'h0);
        run_op("mthi0", 4'd5, 32'h0, 32'h0);
        run_op("maddu", 4'd8, 32'd1, 32'd1);
        check("maddu_const", {bus.HI, bus.LO}, 64'h0000_0001_0000_0000);
        run_op("msubu", 4'd10, 32'd1, 32'd1);
        check("msubu_const", {bus.HI, bus.LO}, 64'h0000_0000_FFFF_FFFF);

        run_op("madd", 4'd7, 32'hFFFF_FFF0, 32'd3);
        run_op("msub", 4'd9, 32'h7FFF_FFFF, 32'h8000_0001);
        run_op("noop", 4'd12, 32'hDEAD_BEEF, 32'd5);
        run_op("none", 4'd0, 32'hCAFE_F00D, 32'd5);

        // Starts issued while busy must be dropped; a start in the first idle cycle must land.
        launch(4'd1, 32'd5, 32'd6, n);
        check("ign_busy1", 64'(bus.busy), 64'(1));
        bus.start = 1'b1; bus.MDctr = 4'd3; bus.A = 32'd100; bus.B = 32'd3;
        @(negedge clk);
        check("ign_busy2", 64'(bus.busy), 64'(1));
        bus.MDctr = 4'd6; bus.A = 32'h5555_5555;
        @(negedge clk);
        bus.start = 1'b0;
        finish("ign_mult", n, 2);
        check("ign_mult_const", {bus.HI, bus.LO}, 64'd30);
        run_op("b2b_div", 4'd3, 32'd100, 32'hFFFF_FFFD);
        check("b2b_div_const", {bus.HI, bus.LO}, 64'h0000_0001_FFFF_FFDF);

        // Reset on the third busy cycle of a divide.
        launch(4'd4, 32'd1000, 32'd7, n);
        void'(sb.pop_back());
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("rmid_busy", 64'(bus.busy), 64'(0));
        check("rmid_hilo", {bus.HI, bus.LO}, 64'(0));
        m_hi = '0;
        m_lo = '0;
        repeat (8) @(negedge clk);
        check("rmid_late_busy", 64'(bus.busy), 64'(0));
        check("rmid_late_hilo", {bus.HI, bus.LO}, 64'(0));

        for (int i = 0; i < 12; i++) begin
            logic [3:0]   op = 4'($urandom_range(1, 10));
            logic [W-1:0] a  = $urandom;
            logic [W-1:0] b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            run_op($sformatf("rnd%0d", i), op, a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
